// File: rtl/sram_responder_pkg.sv
// Shared types for the SRAM pin-level responder: lane masks, read-pipeline
// entries and counter widths.
package sram_pkg;

    localparam int DATA_W       = 16;
    localparam int RD_CNT_W     = 16;
    localparam int WR_CNT_W     = 16;
    localparam int VIO_CNT_W    = 8;
    localparam int READ_LAT_MAX = 3;

    // {UB, LB}, active-high inside the responder
    typedef logic [1:0] lane_mask_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        lane_mask_t        mask;
    } pipe_entry_t;

    function automatic logic [DATA_W-1:0] lane_expand(input lane_mask_t m);
        return {{8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input lane_mask_t        m);
        return (old_w & ~lane_expand(m)) | (new_w & lane_expand(m));
    endfunction

    function automatic pipe_entry_t make_entry(input logic              valid,
                                               input logic [DATA_W-1:0] data,
                                               input lane_mask_t        mask);
        pipe_entry_t e;
        e.valid = valid;
        e.data  = data;
        e.mask  = mask;
        return e;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Control/address pins of the asynchronous SRAM bus; DQ stays a plain inout
// port on the responder so its tristate resolves at the board level.
interface sram_responder_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] SRAM_ADDRIn;
    logic              SRAM_UB_NIn;
    logic              SRAM_LB_NIn;
    logic              SRAM_WE_NIn;
    logic              SRAM_CE_NIn;
    logic              SRAM_OE_NIn;

    modport master (
        output SRAM_ADDRIn, SRAM_UB_NIn, SRAM_LB_NIn,
        output SRAM_WE_NIn, SRAM_CE_NIn, SRAM_OE_NIn
    );

    modport slave (
        input SRAM_ADDRIn, SRAM_UB_NIn, SRAM_LB_NIn,
        input SRAM_WE_NIn, SRAM_CE_NIn, SRAM_OE_NIn
    );
endinterface

// File: rtl/sram_responder_read_pipe.sv
// Fixed-depth shift register of read entries; a new (possibly invalid) entry
// enters every cycle so the tail always reflects the launch DEPTH edges ago.
module sram_read_pipe
    import sram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  pipe_entry_t entry_i,
    output pipe_entry_t entry_o
);

    pipe_entry_t stage_q [DEPTH];
    pipe_entry_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = entry_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign entry_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Pin-level responder for the 16-bit asynchronous SRAM bus: byte-lane writes,
// latency-configurable masked reads, and read/write/violation counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int MEM_AW   = 16,
    parameter int READ_LAT = 1     // 0..READ_LAT_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_responder_if.slave       bus,
    inout  wire  [DATA_W-1:0]     SRAM_DQInOut,
    output logic [RD_CNT_W-1:0]   readCountOut,
    output logic [WR_CNT_W-1:0]   writeCountOut,
    output logic [VIO_CNT_W-1:0]  violationCountOut,
    output logic                  contentionOut
);

    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam logic [VIO_CNT_W-1:0] VIO_MAX = {VIO_CNT_W{1'b1}};

    logic [ADDR_W-1:0]    addr_s;
    logic [MEM_AW-1:0]    mem_idx_s;
    lane_mask_t           lane_s;
    lane_mask_t           drv_s;
    logic                 sel_s;
    logic                 any_lane_s;
    logic                 rd_cond_s;
    logic                 contention_s;
    logic                 write_s;
    logic                 launch_s;
    logic [DATA_W-1:0]    mem_rd_s;
    logic [DATA_W-1:0]    wr_word_s;
    pipe_entry_t          out_entry_s;

    logic [DATA_W-1:0]    mem_q [MEM_DEPTH];
    logic [RD_CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [WR_CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [VIO_CNT_W-1:0] vio_cnt_q, vio_cnt_d;

    assign addr_s    = bus.SRAM_ADDRIn;
    assign mem_idx_s = addr_s[MEM_AW-1:0];

    // Upper address bits alias onto the array and are deliberately ignored
    generate
        if (ADDR_W > MEM_AW) begin : g_alias
            logic unused_addr_hi_s;
            assign unused_addr_hi_s = ^addr_s[ADDR_W-1:MEM_AW];
        end
    endgenerate

    always_comb begin
        sel_s        = ~bus.SRAM_CE_NIn;
        lane_s       = {~bus.SRAM_UB_NIn, ~bus.SRAM_LB_NIn};
        any_lane_s   = |lane_s;
        rd_cond_s    = sel_s & bus.SRAM_WE_NIn & ~bus.SRAM_OE_NIn;
        contention_s = sel_s & ~bus.SRAM_WE_NIn & ~bus.SRAM_OE_NIn;
        write_s      = sel_s & ~bus.SRAM_WE_NIn & any_lane_s;
        launch_s     = rd_cond_s & any_lane_s;
    end

    assign mem_rd_s  = mem_q[mem_idx_s];
    assign wr_word_s = lane_merge(mem_rd_s, SRAM_DQInOut, lane_s);

    // Array has no reset so its contents survive rst
    always_ff @(posedge clk) begin
        if (write_s && !rst) begin
            mem_q[mem_idx_s] <= wr_word_s;
        end
    end

    generate
        if (READ_LAT == 0) begin : g_bypass
            assign out_entry_s = make_entry(~rst, mem_rd_s, lane_s);
        end else begin : g_pipe
            pipe_entry_t launch_entry_s;
            assign launch_entry_s = make_entry(launch_s, mem_rd_s, lane_s);
            sram_read_pipe #(
                .DEPTH (READ_LAT)
            ) u_read_pipe (
                .clk     (clk),
                .rst     (rst),
                .entry_i (launch_entry_s),
                .entry_o (out_entry_s)
            );
        end
    endgenerate

    // A lane drives only if enabled at launch and still enabled now
    assign drv_s = {2{out_entry_s.valid & rd_cond_s}} & out_entry_s.mask & lane_s;
    assign SRAM_DQInOut[15:8] = drv_s[1] ? out_entry_s.data[15:8] : 8'hzz;
    assign SRAM_DQInOut[7:0]  = drv_s[0] ? out_entry_s.data[7:0]  : 8'hzz;

    assign contentionOut = contention_s & ~rst;

    always_comb begin
        rd_cnt_d  = rd_cnt_q + {{(RD_CNT_W-1){1'b0}}, launch_s};
        wr_cnt_d  = wr_cnt_q + {{(WR_CNT_W-1){1'b0}}, write_s};
        vio_cnt_d = vio_cnt_q;
        if (contention_s && any_lane_s && (vio_cnt_q != VIO_MAX)) begin
            vio_cnt_d = vio_cnt_q + {{(VIO_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            vio_cnt_d = vio_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            vio_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            vio_cnt_q <= vio_cnt_d;
        end
    end

    assign readCountOut      = rd_cnt_q;
    assign writeCountOut     = wr_cnt_q;
    assign violationCountOut = vio_cnt_q;

endmodule

// File: doc/sram_responder.md
# sram_responder

Pin-level responder for the 16-bit asynchronous SRAM bus that the SRAM controller drives in the CPU's memory stage. It stores data in an internal array, honours the chip-enable, output-enable, write-enable and byte-lane masks, and returns read data on the shared DQ bus after a configurable number of cycles. It also counts reads, writes and protocol violations. It replaces the plain SRAM model in simulation and in the FPGA build, so the controller's multi-cycle sequencing and freeze path run against a checked responder.

## Interface
Parameters:
- ADDR_W, 18, width of SRAM_ADDRIn
- MEM_AW, 16, log2 of the internal array depth; only address bits [MEM_AW-1:0] are used, so higher bits alias (wrap-around)
- READ_LAT, 1, read latency in cycles, legal range 0..3

Ports:
- clk, in, 1, single clock; all sequential logic uses the rising edge
- rst, in, 1, asynchronous reset, active-high
- SRAM_ADDRIn, in, ADDR_W, word address
- SRAM_DQInOut, inout, 16, bidirectional data bus; high-Z whenever not driving
- SRAM_UB_NIn, in, 1, high-byte lane enable (DQ[15:8]), active-low
- SRAM_LB_NIn, in, 1, low-byte lane enable (DQ[7:0]), active-low
- SRAM_WE_NIn, in, 1, write enable, active-low
- SRAM_CE_NIn, in, 1, chip enable, active-low
- SRAM_OE_NIn, in, 1, output enable, active-low
- readCountOut, out, 16, number of read-launch cycles; wraps
- writeCountOut, out, 16, number of write cycles; wraps
- violationCountOut, out, 8, number of protocol violations; saturates at 255
- contentionOut, out, 1, high during any cycle in which WE_N and OE_N are both low while the chip is selected

## Operation
- sel = ~CE_N. When the chip is not selected, all requests are ignored, nothing is launched, and DQ is high-Z.
- **Write cycle:** sel & ~WE_N, with at least one lane enabled.
  - On the rising edge, each enabled lane of mem[addr] is written from the matching DQ byte.
  - Disabled lanes keep their old value.
  - writeCount increments by 1.
- **Read launch:** sel & WE_N & ~OE_N, with at least one lane enabled.
  - On the rising edge, a pipeline entry {valid, data = mem[addr], lane mask} is pushed. Data is sampled at launch.
  - readCount increments by 1.
  - One read is launched per cycle; back-to-back reads are fully pipelined.
- **Drive rule:** DQ carries the data from the last pipeline stage only when all of these hold: that stage is valid, sel & WE_N & ~OE_N are true in the current cycle, and the lane is enabled in both the launch mask and the current mask. Every other lane is Z.
  - If OE_N rises or CE_N rises, DQ goes to Z combinationally in the same cycle.
- **READ_LAT = 0:** DQ = mem[addr] combinationally, gated by the drive rule. No pipeline is instantiated.
- **Read after write, same address:** a read launched on any edge after the write edge returns the new data.
- **Violation:** sel & ~WE_N & ~OE_N.
  - contentionOut is 1 and violationCount increments, saturating.
  - The write still happens.
  - DQ is not driven, and no read is launched.
- A cycle with no lanes enabled is a no-op and is not counted.
- **Reset (async, including mid-read):**
  - Pipeline valid bits clear immediately and DQ goes to Z.
  - All counters reset to 0 and contentionOut to 0.
  - Memory contents are preserved.

## Timing
- Reset values: DQ Z, readCountOut 0, writeCountOut 0, violationCountOut 0, contentionOut 0.
- Read data for the address presented before edge k appears on DQ after edge k+READ_LAT-1. With READ_LAT=1, that is just after edge k, and it holds until the next launch edge or until the drive conditions drop.
- A write takes effect at its edge. A read launched on the next edge returns the new value.
- Counters update on the edge of the qualifying cycle and are visible after that edge.
- contentionOut is combinational from the control pins.

## Structure
- Package sram_pkg holds:
  - lane mask typedef (2 bits, {UB, LB}, active-high internally)
  - pipeline entry struct {valid, data[15:0], mask[1:0]}
  - counter widths
  - READ_LAT_MAX = 3
- Sub-module sram_read_pipe is a READ_LAT-deep shift register of pipeline entries with async clear. It is bypassed by a generate block when READ_LAT = 0.
- The memory array, write logic, DQ tristate and counters live in the top module.

## Test plan
1. **Full-word write then read.** Write 0xBEEF to address 0x00010 with both lanes enabled, then read with READ_LAT=1 → DQ = 0xBEEF after the launch edge; writeCount = 1, readCount = 1.
2. **Byte-lane write and masked read.** Write 0x1234 to address 0x00020, then write 0xAB00 with UB only → a full read returns 0xAB34; a read with LB only returns 0xZZ34.
3. **Back-to-back reads.** With READ_LAT=2, read addresses 1, 2, 3 on consecutive cycles → data returns on three consecutive cycles in order, and OE_N high mid-burst forces DQ to Z in that cycle.
4. **Contention.** Hold WE_N=0, OE_N=0, CE_N=0 for 3 cycles → contentionOut = 1 and violationCount = 3, the write lands, and DQ stays Z. Repeat for 300 cycles → violationCount = 255.
5. **Reset and aliasing.** Assert rst during an outstanding READ_LAT=3 read → DQ goes to Z immediately, all counters read 0, and memory keeps its data. Separately, with MEM_AW=16, a write to 0x10005 is read back at 0x00005.
